// File: rtl/mux_arb_pkg.sv
// Shared mode encoding and pointer helper for the mux_arb flow-controlled N:1 selector.
package mux_arb_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    function automatic int unsigned rr_ptr_next(input int unsigned g, input int unsigned n);
        return (g == n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/mux_arb_rr_grant.sv
// Combinational rotating-priority grant: first valid channel at or after ptr, wrapping at N_IN-1.
module rr_grant #(
    parameter  int unsigned N_IN  = 4,
    localparam int unsigned SEL_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  valid,
    input  logic [SEL_W-1:0] ptr,
    output logic             gnt_any,
    output logic [SEL_W-1:0] gnt_idx
);

    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N_IN) begin
                idx = idx - N_IN;
            end
            if (!gnt_any && valid[idx[SEL_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = idx[SEL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mux_arb.sv
// N:1 valid/ready selector with one registered output stage; explicit-select or round-robin.
// Optional packet lock in round-robin mode is enabled by defining MUX_ARB_LOCK_EN.
module mux_arb
    import mux_arb_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned N_IN  = 4,
    localparam int unsigned SEL_W = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
`ifdef MUX_ARB_LOCK_EN
    input  logic [N_IN-1:0]       in_last,
    output logic                  out_last,
`endif
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_src
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] src_q, src_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             rr_any;
    logic [SEL_W-1:0] rr_idx;
    logic             sel_hit;
    logic             grant;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             can_accept;
    logic             xfer;

`ifdef MUX_ARB_LOCK_EN
    logic             lock_q, lock_d;
    logic [SEL_W-1:0] lock_idx_q, lock_idx_d;
    logic             last_q, last_d;
    logic             gnt_last;
`endif

    rr_grant #(.N_IN(N_IN)) u_rr_grant (
        .valid   (in_valid),
        .ptr     (ptr_q),
        .gnt_any (rr_any),
        .gnt_idx (rr_idx)
    );

    // Out-of-range sel matches no channel, so it can never grant.
    always_comb begin
        sel_hit = 1'b0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (32'(sel) == i && in_valid[i]) begin
                sel_hit = 1'b1;
            end
        end
        if (mode == MODE_SEL) begin
            grant   = sel_hit;
            gnt_idx = sel;
        end else begin
            grant   = rr_any;
            gnt_idx = rr_idx;
`ifdef MUX_ARB_LOCK_EN
            if (lock_q) begin
                grant   = in_valid[lock_idx_q];
                gnt_idx = lock_idx_q;
            end
`endif
        end
    end

    assign can_accept = !valid_q || out_ready;
    assign xfer       = grant && can_accept && !reset;

    always_comb begin
        gnt_data = '0;
`ifdef MUX_ARB_LOCK_EN
        gnt_last = 1'b0;
`endif
        for (int unsigned i = 0; i < N_IN; i++) begin
            in_ready[i] = xfer && (32'(gnt_idx) == i);
            if (32'(gnt_idx) == i) begin
                gnt_data = in_data[i*WIDTH +: WIDTH];
`ifdef MUX_ARB_LOCK_EN
                gnt_last = in_last[i];
`endif
            end
        end
    end

    always_comb begin
        data_d  = data_q;
        src_d   = src_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
`ifdef MUX_ARB_LOCK_EN
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        last_d     = last_q;
`endif
        if (xfer) begin
            data_d  = gnt_data;
            src_d   = gnt_idx;
            valid_d = 1'b1;
`ifdef MUX_ARB_LOCK_EN
            last_d  = gnt_last;
`endif
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        // In round-robin the pointer moves past the winner; with lock only at packet end.
        if (xfer && mode == MODE_RR) begin
`ifdef MUX_ARB_LOCK_EN
            lock_d     = !gnt_last;
            lock_idx_d = gnt_idx;
            if (gnt_last) begin
                ptr_d = SEL_W'(rr_ptr_next(32'(gnt_idx), N_IN));
            end
`else
            ptr_d = SEL_W'(rr_ptr_next(32'(gnt_idx), N_IN));
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            src_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            data_q  <= data_d;
            src_q   <= src_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef MUX_ARB_LOCK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            last_q     <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            last_q     <= last_d;
        end
    end

    assign out_last = last_q;
`endif

    assign out_data  = data_q;
    assign out_src   = src_q;
    assign out_valid = valid_q;

endmodule
